// File: rtl/jump_ctrl.sv
// jump_ctrl: top-level turn sequencer for the jump game.
// It charges the jump while the button is held, hands off to the jump
// datapath, judges the landing, runs the scroll datapath and then spawns
// the next stage. It owns the man/stage coordinates, the score and the
// game-over flag.
//
// Optional feature macro: CENTER_BONUS_EN
//   defined   - a hit within 3 px of the target stage centre scores 2, and
//               o_center_hit pulses for one cycle on entry to MOVE.
//   undefined - every hit scores 1 and o_center_hit does not exist.
module jump_ctrl #(
    parameter int         MAX_DIST  = 300,
    parameter int         STAGE_W   = 40,
    parameter int         MIN_GAP   = 30,
    parameter int         X_MAX     = 639,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pulse,
    input  logic       i_btn,
    input  logic       i_start,
    input  logic       i_jump_fin,
    input  logic [9:0] i_man_x_land,
    input  logic       i_move_fin,
    input  logic [9:0] i_moved_man_x,
    input  logic [9:0] i_moved_stage1_x,
    output logic       o_jump_en,
    output logic [9:0] o_jump_dist,
    output logic       o_move_en,
    output logic [9:0] o_man_x,
    output logic [9:0] o_stage0_x,
    output logic [9:0] o_stage1_x,
    output logic [7:0] o_score,
    output logic       o_game_over,
    output logic [2:0] o_state
`ifdef CENTER_BONUS_EN
    ,
    output logic       o_center_hit
`endif
);

    // State encodings are fixed; they are visible on o_state.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHARGE = 3'd1;
    localparam logic [2:0] ST_JUMP   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_MOVE   = 3'd4;
    localparam logic [2:0] ST_SPAWN  = 3'd5;
    localparam logic [2:0] ST_OVER   = 3'd6;

    // Start-of-game layout, shared by reset and the restart request.
    localparam logic [9:0]  RST_MAN_X    = 10'd60;
    localparam logic [9:0]  RST_STAGE0_X = 10'd40;
    localparam logic [9:0]  RST_STAGE1_X = 10'd200;

    // Width-matched copies of the parameters for the 11-bit arithmetic.
    localparam logic [9:0]  MAX_DIST_C   = 10'(MAX_DIST);
    localparam logic [10:0] STAGE_W_C    = 11'(STAGE_W);
    localparam logic [10:0] SPAWN_OFS_C  = 11'(STAGE_W + MIN_GAP);
    localparam logic [10:0] SPAWN_MAX_C  = 11'(X_MAX - STAGE_W);
`ifdef CENTER_BONUS_EN
    localparam logic [10:0] HALF_W_C     = 11'(STAGE_W / 2);
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [9:0]  r_jump_dist;
    logic [9:0]  r_man_x;
    logic [9:0]  r_stage0_x;
    logic [9:0]  r_stage1_x;
    logic [7:0]  r_score;
    logic [9:0]  r_land_x;
    logic [9:0]  r_moved_man_x;
    logic [9:0]  r_moved_s1_x;
    logic [7:0]  r_lfsr;
    logic        r_jump_en;
    logic        r_move_en;
    logic        r_game_over;

    logic [10:0] w_land_ext;
    logic [10:0] w_s0_ext;
    logic [10:0] w_s1_ext;
    logic [10:0] w_s0_end;
    logic [10:0] w_s1_end;
    logic        w_hit;
    logic        w_hop;
    logic [10:0] w_dist_sum;
    logic [9:0]  w_dist_inc;
    logic [10:0] w_spawn_sum;
    logic [9:0]  w_spawn_x;
    logic [7:0]  w_score_add;
    logic [8:0]  w_score_sum;
    logic [7:0]  w_score_next;
    logic        w_lfsr_fb;
    logic [7:0]  w_lfsr_next;

    // Landing windows: [x, x+STAGE_W) on each stage, computed 11-bit so the
    // right edge of a stage near X_MAX cannot wrap.
    assign w_land_ext = {1'b0, r_land_x};
    assign w_s0_ext   = {1'b0, r_stage0_x};
    assign w_s1_ext   = {1'b0, r_stage1_x};
    assign w_s0_end   = w_s0_ext + STAGE_W_C;
    assign w_s1_end   = w_s1_ext + STAGE_W_C;
    assign w_hit      = (w_land_ext >= w_s1_ext) && (w_land_ext < w_s1_end);
    assign w_hop      = (w_land_ext >= w_s0_ext) && (w_land_ext < w_s0_end);

    // Charge step of 2 px, saturating at MAX_DIST.
    assign w_dist_sum = {1'b0, r_jump_dist} + 11'd2;
    assign w_dist_inc = (w_dist_sum > {1'b0, MAX_DIST_C}) ? MAX_DIST_C : w_dist_sum[9:0];

    // Next stage lands a random 0..127 px beyond the minimum gap, clamped so
    // the whole stage stays on screen.
    assign w_spawn_sum = {1'b0, r_moved_s1_x} + SPAWN_OFS_C + {4'b0, r_lfsr[6:0]};
    assign w_spawn_x   = (w_spawn_sum > SPAWN_MAX_C) ? SPAWN_MAX_C[9:0] : w_spawn_sum[9:0];

`ifdef CENTER_BONUS_EN
    logic [10:0] w_center;
    logic [10:0] w_center_diff;
    logic        w_center_hit;
    logic        r_center_hit;

    // Distance from the landing point to the target stage centre.
    assign w_center      = w_s1_ext + HALF_W_C;
    assign w_center_diff = (w_land_ext >= w_center) ? (w_land_ext - w_center)
                                                    : (w_center - w_land_ext);
    assign w_center_hit  = w_hit && (w_center_diff < 11'd4);
    assign w_score_add   = w_center_hit ? 8'd2 : 8'd1;
    assign o_center_hit  = r_center_hit;
`else
    assign w_score_add   = 8'd1;
`endif

    // Score saturates at 255.
    assign w_score_sum  = {1'b0, r_score} + {1'b0, w_score_add};
    assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

    // 8-bit Fibonacci LFSR, taps 8,6,5,4; a zero state is never loaded.
    assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_lfsr_next = ({r_lfsr[6:0], w_lfsr_fb} == 8'h00) ? LFSR_SEED
                                                              : {r_lfsr[6:0], w_lfsr_fb};

    // Next-state decode for one turn of the game.
    always_comb begin
        // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_btn) w_next_state = ST_CHARGE;
            ST_CHARGE: if (!i_btn) w_next_state = (r_jump_dist == 10'd0) ? ST_IDLE : ST_JUMP;
            ST_JUMP:   if (i_jump_fin) w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (w_hit)      w_next_state = ST_MOVE;
                else if (w_hop) w_next_state = ST_IDLE;
                else            w_next_state = ST_OVER;
            end
            ST_MOVE:   if (i_move_fin) w_next_state = ST_SPAWN;
            ST_SPAWN:  w_next_state = ST_IDLE;
            ST_OVER:   if (i_start) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // State register and state-decoded enables, registered from next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_jump_en   <= 1'b0;
            r_move_en   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_jump_en   <= (w_next_state == ST_JUMP);
            r_move_en   <= (w_next_state == ST_MOVE);
            r_game_over <= (w_next_state == ST_OVER);
        end
    end

    // Jump distance: charged on pulses while held, frozen through JUMP and
    // CHECK, cleared whenever the FSM is heading into IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_dist <= 10'd0;
        end else if (w_next_state == ST_IDLE) begin
            r_jump_dist <= 10'd0;
        end else if ((r_state == ST_CHARGE) && i_btn && i_pulse) begin
            r_jump_dist <= w_dist_inc;
        end
    end

    // Coordinates, score and the captured datapath results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_man_x       <= RST_MAN_X;
            r_stage0_x    <= RST_STAGE0_X;
            r_stage1_x    <= RST_STAGE1_X;
            r_score       <= 8'd0;
            r_land_x      <= 10'd0;
            r_moved_man_x <= 10'd0;
            r_moved_s1_x  <= 10'd0;
        end else begin
            case (r_state)
                ST_JUMP: begin
                    if (i_jump_fin) r_land_x <= i_man_x_land;
                end
                ST_CHECK: begin
                    if (w_hit) begin
                        r_man_x <= r_land_x;
                        r_score <= w_score_next;
                    end else if (w_hop) begin
                        r_man_x <= r_land_x;
                    end
                end
                ST_MOVE: begin
                    if (i_move_fin) begin
                        r_moved_man_x <= i_moved_man_x;
                        r_moved_s1_x  <= i_moved_stage1_x;
                    end
                end
                ST_SPAWN: begin
                    r_man_x    <= r_moved_man_x;
                    r_stage0_x <= r_moved_s1_x;
                    r_stage1_x <= w_spawn_x;
                end
                ST_OVER: begin
                    if (i_start) begin
                        r_man_x       <= RST_MAN_X;
                        r_stage0_x    <= RST_STAGE0_X;
                        r_stage1_x    <= RST_STAGE1_X;
                        r_score       <= 8'd0;
                        r_land_x      <= 10'd0;
                        r_moved_man_x <= 10'd0;
                        r_moved_s1_x  <= 10'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Spawn LFSR free-runs every cycle; restart does not reseed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= w_lfsr_next;
    end

`ifdef CENTER_BONUS_EN
    // One-cycle centre-hit flag aligned with the CHECK->MOVE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_center_hit <= 1'b0;
        else        r_center_hit <= (r_state == ST_CHECK) && w_center_hit;
    end
`endif

    assign o_jump_en   = r_jump_en;
    assign o_jump_dist = r_jump_dist;
    assign o_move_en   = r_move_en;
    assign o_man_x     = r_man_x;
    assign o_stage0_x  = r_stage0_x;
    assign o_stage1_x  = r_stage1_x;
    assign o_score     = r_score;
    assign o_game_over = r_game_over;
    assign o_state     = r_state;

endmodule

// File: tb/tb_jump_ctrl.sv
// tb_jump_ctrl: directed bench for jump_ctrl. Inputs change and outputs are
// sampled 1 ns after the rising edge.
module tb_jump_ctrl;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHARGE = 3'd1;
    localparam logic [2:0] ST_JUMP   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_MOVE   = 3'd4;
    localparam logic [2:0] ST_SPAWN  = 3'd5;
    localparam logic [2:0] ST_OVER   = 3'd6;

`ifdef CENTER_BONUS_EN
    localparam int BONUS_ADD = 2;
`else
    localparam int BONUS_ADD = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       i_pulse;
    logic       i_btn;
    logic       i_start;
    logic       i_jump_fin;
    logic [9:0] i_man_x_land;
    logic       i_move_fin;
    logic [9:0] i_moved_man_x;
    logic [9:0] i_moved_stage1_x;
    logic       o_jump_en;
    logic [9:0] o_jump_dist;
    logic       o_move_en;
    logic [9:0] o_man_x;
    logic [9:0] o_stage0_x;
    logic [9:0] o_stage1_x;
    logic [7:0] o_score;
    logic       o_game_over;
    logic [2:0] o_state;
`ifdef CENTER_BONUS_EN
    logic       o_center_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    jump_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_pulse          (i_pulse),
        .i_btn            (i_btn),
        .i_start          (i_start),
        .i_jump_fin       (i_jump_fin),
        .i_man_x_land     (i_man_x_land),
        .i_move_fin       (i_move_fin),
        .i_moved_man_x    (i_moved_man_x),
        .i_moved_stage1_x (i_moved_stage1_x),
        .o_jump_en        (o_jump_en),
        .o_jump_dist      (o_jump_dist),
        .o_move_en        (o_move_en),
        .o_man_x          (o_man_x),
        .o_stage0_x       (o_stage0_x),
        .o_stage1_x       (o_stage1_x),
        .o_score          (o_score),
        .o_game_over      (o_game_over),
        .o_state          (o_state)
`ifdef CENTER_BONUS_EN
        ,
        .o_center_hit     (o_center_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference spawn LFSR: x^8+x^6+x^5+x^4, seed A5, shifts every clock.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; i_pulse = 1'b0; i_btn = 1'b0; i_start = 1'b0;
        i_jump_fin = 1'b0; i_man_x_land = 10'd0; i_move_fin = 1'b0;
        i_moved_man_x = 10'd0; i_moved_stage1_x = 10'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // IDLE -> CHARGE, n pulses, release: ends in JUMP.
    task automatic charge(input int n);
        i_btn = 1'b1; tick();
        for (int i = 0; i < n; i++) begin
            i_pulse = 1'b1; tick(); i_pulse = 1'b0;
        end
        i_btn = 1'b0; tick();
    endtask

    // JUMP: report landing at x; returns after the CHECK cycle.
    task automatic land(input logic [9:0] x);
        i_man_x_land = x; i_jump_fin = 1'b1; tick(); i_jump_fin = 1'b0;
        tick();
    endtask

    // MOVE: datapath finishes with the given coordinates; ends in IDLE.
    task automatic finish_move(input logic [9:0] mm, input logic [9:0] ms);
        i_moved_man_x = mm; i_moved_stage1_x = ms; i_move_fin = 1'b1; tick();
        i_move_fin = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_pulse = 1'b0; i_btn = 1'b0; i_start = 1'b0;
        i_jump_fin = 1'b0; i_man_x_land = 10'd0; i_move_fin = 1'b0;
        i_moved_man_x = 10'd0; i_moved_stage1_x = 10'd0;
        tick(); tick();
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", o_state, ST_IDLE); end
        n_checks++; if (o_man_x !== 10'd60) begin n_fail++; $display("FAIL reset_man_x: got %0d exp 60", o_man_x); end
        n_checks++; if (o_stage0_x !== 10'd40) begin n_fail++; $display("FAIL reset_stage0_x: got %0d exp 40", o_stage0_x); end
        n_checks++; if (o_stage1_x !== 10'd200) begin n_fail++; $display("FAIL reset_stage1_x: got %0d exp 200", o_stage1_x); end
        n_checks++; if (o_score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d exp 0", o_score); end
        n_checks++; if (o_jump_dist !== 10'd0) begin n_fail++; $display("FAIL reset_jump_dist: got %0d exp 0", o_jump_dist); end
        n_checks++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL reset_jump_en: got %b exp 0", o_jump_en); end
        n_checks++; if (o_move_en !== 1'b0) begin n_fail++; $display("FAIL reset_move_en: got %b exp 0", o_move_en); end
        n_checks++; if (o_game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b exp 0", o_game_over); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_charge();
        // Press and release without a pulse: back to IDLE.
        i_btn = 1'b1; tick();
        n_checks++; if (o_state !== ST_CHARGE) begin n_fail++; $display("FAIL charge_enter: got %0d exp %0d", o_state, ST_CHARGE); end
        i_btn = 1'b0; tick();
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL charge_zero_release: got %0d exp %0d", o_state, ST_IDLE); end
        // Ten pulses, then release coinciding with a pulse.
        i_btn = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin
            i_pulse = 1'b1; tick(); i_pulse = 1'b0;
        end
        n_checks++; if (o_jump_dist !== 10'd20) begin n_fail++; $display("FAIL charge_dist10: got %0d exp 20", o_jump_dist); end
        n_checks++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL charge_jump_en_early: got %b exp 0", o_jump_en); end
        i_btn = 1'b0; i_pulse = 1'b1; tick(); i_pulse = 1'b0;
        n_checks++; if (o_state !== ST_JUMP) begin n_fail++; $display("FAIL charge_to_jump: got %0d exp %0d", o_state, ST_JUMP); end
        n_checks++; if (o_jump_en !== 1'b1) begin n_fail++; $display("FAIL charge_jump_en: got %b exp 1", o_jump_en); end
        n_checks++; if (o_jump_dist !== 10'd20) begin n_fail++; $display("FAIL charge_release_wins: got %0d exp 20", o_jump_dist); end
    endtask

    // Continues from test_charge (JUMP, dist 20).
    task automatic test_hit();
        logic [9:0] exp_s1;
        i_man_x_land = 10'd210; i_jump_fin = 1'b1; tick(); i_jump_fin = 1'b0;
        n_checks++; if (o_state !== ST_CHECK) begin n_fail++; $display("FAIL hit_check_state: got %0d exp %0d", o_state, ST_CHECK); end
        n_checks++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL hit_jump_en_fall: got %b exp 0", o_jump_en); end
        n_checks++; if (o_jump_dist !== 10'd20) begin n_fail++; $display("FAIL hit_dist_held: got %0d exp 20", o_jump_dist); end
        tick();
        n_checks++; if (o_state !== ST_MOVE) begin n_fail++; $display("FAIL hit_move_state: got %0d exp %0d", o_state, ST_MOVE); end
        n_checks++; if (o_score !== 8'd1) begin n_fail++; $display("FAIL hit_score: got %0d exp 1", o_score); end
        n_checks++; if (o_man_x !== 10'd210) begin n_fail++; $display("FAIL hit_man_x: got %0d exp 210", o_man_x); end
        tick(); tick(); tick();
        n_checks++; if (o_move_en !== 1'b1) begin n_fail++; $display("FAIL hit_move_en_held: got %b exp 1", o_move_en); end
        i_moved_man_x = 10'd60; i_moved_stage1_x = 10'd50; i_move_fin = 1'b1; tick(); i_move_fin = 1'b0;
        n_checks++; if (o_state !== ST_SPAWN) begin n_fail++; $display("FAIL hit_spawn_state: got %0d exp %0d", o_state, ST_SPAWN); end
        n_checks++; if (o_move_en !== 1'b0) begin n_fail++; $display("FAIL hit_move_en_fall: got %b exp 0", o_move_en); end
        exp_s1 = 10'd120 + {3'b0, m_lfsr[6:0]};
        tick();
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL spawn_idle: got %0d exp %0d", o_state, ST_IDLE); end
        n_checks++; if (o_stage0_x !== 10'd50) begin n_fail++; $display("FAIL spawn_stage0: got %0d exp 50", o_stage0_x); end
        n_checks++; if (o_man_x !== 10'd60) begin n_fail++; $display("FAIL spawn_man_x: got %0d exp 60", o_man_x); end
        n_checks++; if (o_stage1_x !== exp_s1) begin n_fail++; $display("FAIL spawn_stage1: got %0d exp %0d", o_stage1_x, exp_s1); end
        n_checks++; if (o_jump_dist !== 10'd0) begin n_fail++; $display("FAIL spawn_dist_clear: got %0d exp 0", o_jump_dist); end
    endtask

    task automatic test_short_hop();
        do_reset();
        charge(5);
        i_man_x_land = 10'd70; i_jump_fin = 1'b1; tick(); i_jump_fin = 1'b0;
        n_checks++; if (o_move_en !== 1'b0) begin n_fail++; $display("FAIL hop_move_en_check: got %b exp 0", o_move_en); end
        tick();
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL hop_state: got %0d exp %0d", o_state, ST_IDLE); end
        n_checks++; if (o_man_x !== 10'd70) begin n_fail++; $display("FAIL hop_man_x: got %0d exp 70", o_man_x); end
        n_checks++; if (o_score !== 8'd0) begin n_fail++; $display("FAIL hop_score: got %0d exp 0", o_score); end
        n_checks++; if (o_move_en !== 1'b0) begin n_fail++; $display("FAIL hop_move_en: got %b exp 0", o_move_en); end
        // Restart outside OVER has no effect.
        i_start = 1'b1; tick(); i_start = 1'b0;
        n_checks++; if (o_man_x !== 10'd70) begin n_fail++; $display("FAIL start_ignored: got %0d exp 70", o_man_x); end
    endtask

    task automatic test_miss();
        do_reset();
        charge(2); land(10'd210); finish_move(10'd60, 10'd50);
        // Stage0 now 50..89, stage1 at least 120: landing 100 misses both.
        charge(3); land(10'd100);
        n_checks++; if (o_state !== ST_OVER) begin n_fail++; $display("FAIL miss_state: got %0d exp %0d", o_state, ST_OVER); end
        n_checks++; if (o_game_over !== 1'b1) begin n_fail++; $display("FAIL miss_game_over: got %b exp 1", o_game_over); end
        n_checks++; if (o_score !== 8'd1) begin n_fail++; $display("FAIL miss_score_kept: got %0d exp 1", o_score); end
        i_btn = 1'b1; tick(); i_btn = 1'b0;
        n_checks++; if (o_state !== ST_OVER) begin n_fail++; $display("FAIL over_holds: got %0d exp %0d", o_state, ST_OVER); end
        i_start = 1'b1; tick(); i_start = 1'b0;
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL restart_state: got %0d exp %0d", o_state, ST_IDLE); end
        n_checks++; if (o_game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %b exp 0", o_game_over); end
        n_checks++; if (o_score !== 8'd0) begin n_fail++; $display("FAIL restart_score: got %0d exp 0", o_score); end
        n_checks++; if (o_man_x !== 10'd60) begin n_fail++; $display("FAIL restart_man_x: got %0d exp 60", o_man_x); end
        n_checks++; if (o_stage0_x !== 10'd40) begin n_fail++; $display("FAIL restart_stage0: got %0d exp 40", o_stage0_x); end
        n_checks++; if (o_stage1_x !== 10'd200) begin n_fail++; $display("FAIL restart_stage1: got %0d exp 200", o_stage1_x); end
        // Right edge of stage0 is exclusive: 80 on 40..79 is a miss.
        charge(1); land(10'd80);
        n_checks++; if (o_state !== ST_OVER) begin n_fail++; $display("FAIL miss_edge80: got %0d exp %0d", o_state, ST_OVER); end
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    task automatic test_saturation_clamp();
        do_reset();
        charge(200);
        n_checks++; if (o_jump_dist !== 10'd300) begin n_fail++; $display("FAIL sat_dist: got %0d exp 300", o_jump_dist); end
        land(10'd200);
        n_checks++; if (o_state !== ST_MOVE) begin n_fail++; $display("FAIL hit_left_edge: got %0d exp %0d", o_state, ST_MOVE); end
        finish_move(10'd60, 10'd560);
        n_checks++; if (o_stage1_x !== 10'd599) begin n_fail++; $display("FAIL clamp_stage1: got %0d exp 599", o_stage1_x); end
        n_checks++; if (o_stage0_x !== 10'd560) begin n_fail++; $display("FAIL clamp_stage0: got %0d exp 560", o_stage0_x); end
        // Last pixel of the target stage still counts as a hit.
        do_reset();
        charge(1); land(10'd239);
        n_checks++; if (o_state !== ST_MOVE) begin n_fail++; $display("FAIL hit_right_edge: got %0d exp %0d", o_state, ST_MOVE); end
    endtask

    task automatic test_reset_mid_turn();
        do_reset();
        charge(2);
        #2 rst_n = 1'b0; #1;
        n_checks++; if (o_jump_en !== 1'b0) begin n_fail++; $display("FAIL abort_jump_en: got %b exp 0", o_jump_en); end
        n_checks++; if (o_state !== ST_IDLE) begin n_fail++; $display("FAIL abort_jump_state: got %0d exp %0d", o_state, ST_IDLE); end
        do_reset();
        charge(2); land(10'd210);
        #2 rst_n = 1'b0; #1;
        n_checks++; if (o_move_en !== 1'b0) begin n_fail++; $display("FAIL abort_move_en: got %b exp 0", o_move_en); end
        n_checks++; if (o_score !== 8'd0) begin n_fail++; $display("FAIL abort_score: got %0d exp 0", o_score); end
    endtask

    task automatic bonus_case(input logic [9:0] x, input int exp_add, input logic exp_center);
        do_reset();
        charge(1); land(x);
        n_checks++; if (o_score !== 8'(exp_add)) begin n_fail++; $display("FAIL bonus_score_%0d: got %0d exp %0d", x, o_score, exp_add); end
`ifdef CENTER_BONUS_EN
        n_checks++; if (o_center_hit !== exp_center) begin n_fail++; $display("FAIL center_hit_%0d: got %b exp %b", x, o_center_hit, exp_center); end
        tick();
        n_checks++; if (o_center_hit !== 1'b0) begin n_fail++; $display("FAIL center_hit_pulse_%0d: got %b exp 0", x, o_center_hit); end
`else
        if (exp_center) tick();
`endif
    endtask

    task automatic test_bonus();
        bonus_case(10'd221, BONUS_ADD, 1'b1);
        bonus_case(10'd224, 1, 1'b0);
        bonus_case(10'd210, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_charge();
        test_hit();
        test_short_hop();
        test_miss();
        test_saturation_clamp();
        test_reset_mid_turn();
        test_bonus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jump_ctrl.md
# jump_ctrl

Top-level sequencer for the jump game. Drives one turn end to end:
- charges jump power while the button is held;
- hands the jump to the jump datapath and waits for it to finish;
- checks where the man landed;
- enables the scroll (move) datapath and waits for it to finish;
- spawns the next stage.

It owns the man and stage coordinate registers, the score and the game-over flag. It sits between input conditioning and the move/jump/render blocks.

## Interface
Parameters:
- MAX_DIST, 300, saturation limit of jump_dist (pixels)
- STAGE_W, 40, stage width (pixels)
- MIN_GAP, 30, minimum empty gap between stages
- X_MAX, 639, rightmost legal pixel column
- LFSR_SEED, 8'hA5, reset value of the spawn LFSR (non-zero)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pulse  in  1  one-cycle motion tick
- btn  in  1  jump button, synchronised level
- start  in  1  one-cycle restart request
- jump_fin  in  1  jump datapath done (level)
- man_x_land  in  10  man x at landing, valid with jump_fin
- move_fin  in  1  move datapath done (level)
- moved_man_x  in  10  man x from move datapath
- moved_stage1_x  in  10  stage1 x from move datapath
- jump_en  out  1  jump datapath enable
- jump_dist  out  10  charged jump distance
- move_en  out  1  move datapath enable
- man_x  out  10  man x (left edge)
- stage0_x  out  10  current stage x (left edge)
- stage1_x  out  10  target stage x (left edge)
- score  out  8  score, saturating
- game_over  out  1  high in OVER
- state  out  3  current FSM state encoding

## Operation
The FSM has seven states with encodings IDLE=0, CHARGE=1, JUMP=2, CHECK=3, MOVE=4, SPAWN=5, OVER=6.

- IDLE:
  - jump_dist is held at 0.
  - btn high goes to CHARGE.
- CHARGE:
  - On each pulse while btn is high, jump_dist += 2, saturating at MAX_DIST.
  - btn low with jump_dist==0 goes to IDLE.
  - btn low with jump_dist>0 goes to JUMP.
- JUMP:
  - jump_en=1.
  - jump_fin goes to CHECK; man_x_land is captured into land_x on the same edge.
- CHECK (one cycle). Sets s1_end = stage1_x + STAGE_W, computed 11-bit.
  - stage1_x ≤ land_x < s1_end: hit. man_x<=land_x, score += 1 (saturating at 255), next state MOVE.
  - Otherwise, stage0_x ≤ land_x < stage0_x+STAGE_W: short hop. man_x<=land_x, score unchanged, next state IDLE.
  - Otherwise: go to OVER.
- MOVE:
  - move_en=1; wait for move_fin.
  - On move_fin, capture moved_man_x and moved_stage1_x, then go to SPAWN.
- SPAWN (one cycle):
  - man_x<=moved man x.
  - stage0_x<=moved stage1 x.
  - stage1_x<=moved stage1 x + STAGE_W + MIN_GAP + lfsr[6:0], computed 11-bit and clamped to X_MAX−STAGE_W.
  - Next state IDLE.
- OVER:
  - game_over=1.
  - start restores all reset values except the LFSR, then goes to IDLE.
- start in any state other than OVER is ignored.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Shifts every clk regardless of state.
  - Never loaded with zero.
- jump_dist is held through JUMP and CHECK and cleared on entry to IDLE.

## Timing
- Reset (async assert, sync deassert use):
  - state=IDLE, man_x=60, stage0_x=40, stage1_x=200, score=0.
  - jump_dist=0, jump_en=0, move_en=0, game_over=0, lfsr=LFSR_SEED.
- All outputs are registered; state-decoded enables change on the edge the state changes.
- jump_en rises the cycle after the btn-release edge is sampled. It falls on the edge that samples jump_fin.
- move_en is continuous through MOVE; the datapath reloads its coordinates whenever move_en is low. move_en falls on the edge that samples move_fin.
- Landing latency: jump_fin edge → CHECK (1 cycle) → MOVE/IDLE/OVER on the following edge.
- Simultaneous pulse and btn release in CHARGE: the release wins and jump_dist is not incremented.
- Reset asserted mid-turn (any state) aborts the turn immediately with both enables low.

## Configuration
- CENTER_BONUS_EN defined:
  - A hit with |land_x − (stage1_x + STAGE_W/2)| < 4 adds 2 instead of 1, still saturating at 255.
  - A registered center_hit output pulses for the CHECK→MOVE edge.
- CENTER_BONUS_EN undefined: every hit adds 1, and no center_hit port exists.

## Test plan
- Reset then idle: rst_n low → all reset values; btn held 10 pulses → jump_dist=20. Release → jump_en=1 the next cycle.
- Hit: stage1_x=200, land 210 → CHECK → score=1, move_en=1. Assert move_fin with moved_man_x=60 and moved_stage1_x=50 → SPAWN → stage0_x=50, man_x=60, stage1_x=120+lfsr[6:0].
- Short hop: stage0_x=40, land 70 → IDLE, man_x=70, score unchanged, move_en never high.
- Miss: land 100 with stage0 40–79 and stage1 200–239 → OVER, game_over=1. start → IDLE with reset values.
- Saturation and clamp: btn held 200 pulses → jump_dist=300. Spawn with moved_stage1_x=560 → stage1_x=599.
- Bonus (CENTER_BONUS_EN): land 221 on stage1_x=200 → score +2, center_hit pulse. Land 210 → +1.
